// File: rtl/rv32i_mc_core.sv
// Multi-cycle RV32I core: FETCH/EXEC/MEM/TRAP sequencer with req/ready memory handshakes and a wait watchdog.
// Defining RV32I_MC_PERF_CNT_EN builds the cycle and retired-instruction counters.
module rv32i_mc_core #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned WAIT_LIMIT = 0
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imemaddr,
    output logic        imemreq,
    input  logic        imemready,
    input  logic [31:0] imemdataout,
    output logic [31:0] dmemaddr,
    output logic [31:0] dmemdatain,
    input  logic [31:0] dmemdataout,
    output logic [2:0]  dmemop,
    output logic        dmemwe,
    output logic        dmemreq,
    input  logic        dmemready,
    output logic        trap,
    output logic [1:0]  trapcause,
    output logic        retire,
    output logic [31:0] cyclecnt,
    output logic [31:0] instretcnt,
    output logic [31:0] dbgdata
);
    typedef enum logic [1:0] {FETCH, EXEC, MEM, TRAP} state_t;

    localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6F, OP_JALR = 7'h67;
    localparam logic [6:0] OP_BRANCH = 7'h63, OP_LOAD = 7'h03, OP_STORE = 7'h23;
    localparam logic [6:0] OP_IMM = 7'h13, OP_REG = 7'h33;

    state_t      state, state_next;
    logic [31:0] pc, pc_next, ir, wait_cnt;
    logic [1:0]  cause_q, cause_next;
    logic [31:0] regs [32];
    logic        reg_we;
    logic [31:0] reg_wdata;

    logic [6:0]  opcode;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] rs1_val, rs2_val, alu_b, alu_res, pc_plus4;
    logic        legal, is_ldst, writes_rd, taken, wait_cycle, timeout;

    assign opcode = ir[6:0];
    assign rd     = ir[11:7];
    assign funct3 = ir[14:12];
    assign rs1    = ir[19:15];
    assign rs2    = ir[24:20];
    assign imm_i  = {{20{ir[31]}}, ir[31:20]};
    assign imm_s  = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b  = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u  = {ir[31:12], 12'b0};
    assign imm_j  = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

    assign rs1_val  = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val  = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign pc_plus4 = pc + 32'd4;

    assign legal     = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                      OP_LOAD, OP_STORE, OP_IMM, OP_REG};
    assign is_ldst   = (opcode == OP_LOAD) || (opcode == OP_STORE);
    assign writes_rd = opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_IMM, OP_REG};

    assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;

    always_comb begin
        alu_res = '0;
        case (funct3)
            3'b000:  alu_res = (opcode == OP_REG && ir[30]) ? rs1_val - alu_b : rs1_val + alu_b;
            3'b001:  alu_res = rs1_val << alu_b[4:0];
            3'b010:  alu_res = {31'b0, $signed(rs1_val) < $signed(alu_b)};
            3'b011:  alu_res = {31'b0, rs1_val < alu_b};
            3'b100:  alu_res = rs1_val ^ alu_b;
            3'b101:  alu_res = ir[30] ? 32'($signed(rs1_val) >>> alu_b[4:0]) : rs1_val >> alu_b[4:0];
            3'b110:  alu_res = rs1_val | alu_b;
            default: alu_res = rs1_val & alu_b;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000:  taken = rs1_val == rs2_val;
            3'b001:  taken = rs1_val != rs2_val;
            3'b100:  taken = $signed(rs1_val) <  $signed(rs2_val);
            3'b101:  taken = $signed(rs1_val) >= $signed(rs2_val);
            3'b110:  taken = rs1_val <  rs2_val;
            3'b111:  taken = rs1_val >= rs2_val;
            default: taken = 1'b0;
        endcase
    end

    assign imemreq   = (state == FETCH) && !reset;
    assign dmemreq   = (state == MEM) && !reset;
    assign imemaddr  = pc;
    assign dbgdata   = pc;
    assign trap      = (state == TRAP) && !reset;
    assign trapcause = reset ? 2'd0 : cause_q;

    // The limit is reached on the edge that ends the WAIT_LIMIT-th unacknowledged cycle.
    assign wait_cycle = (imemreq && !imemready) || (dmemreq && !dmemready);
    assign timeout    = (WAIT_LIMIT != 0) && wait_cycle && (wait_cnt == WAIT_LIMIT - 1);

    // NOTE: every output of this block gets a default first, otherwise untouched paths infer latches.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        cause_next = cause_q;
        reg_we     = 1'b0;
        reg_wdata  = '0;
        retire     = 1'b0;
        case (state)
            FETCH: begin
                if (imemready) begin
                    state_next = EXEC;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = 2'd2;
                end
            end
            EXEC: begin
                if (!legal) begin
                    state_next = TRAP;
                    cause_next = 2'd1;
                end else if (is_ldst) begin
                    state_next = MEM;
                end else begin
                    reg_we  = writes_rd;
                    retire  = 1'b1;
                    pc_next = pc_plus4;
                    case (opcode)
                        OP_LUI:   reg_wdata = imm_u;
                        OP_AUIPC: reg_wdata = pc + imm_u;
                        OP_JAL:   begin reg_wdata = pc_plus4; pc_next = pc + imm_j; end
                        OP_JALR:  begin reg_wdata = pc_plus4; pc_next = (rs1_val + imm_i) & ~32'd1; end
                        OP_BRANCH: if (taken) pc_next = pc + imm_b;
                        default:  reg_wdata = alu_res;
                    endcase
                    state_next = FETCH;
                end
            end
            MEM: begin
                if (dmemready) begin
                    reg_we     = !dmemwe;
                    reg_wdata  = dmemdataout;
                    pc_next    = pc_plus4;
                    retire     = 1'b1;
                    state_next = FETCH;
                end else if (timeout) begin
                    state_next = TRAP;
                    cause_next = 2'd3;
                end
            end
            default: ;
        endcase
        if (reset) begin
            retire = 1'b0;
            reg_we = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= FETCH;
            pc       <= RESET_PC;
            cause_q  <= 2'd0;
            wait_cnt <= '0;
        end else begin
            state    <= state_next;
            pc       <= pc_next;
            cause_q  <= cause_next;
            wait_cnt <= wait_cycle ? wait_cnt + 32'd1 : '0;
        end
    end

    // Instruction and memory-request operands are pure datapath registers, held by their enables.
    always_ff @(posedge clock) begin
        if (state == FETCH && imemready && !reset)
            ir <= imemdataout;
        if (state == EXEC && is_ldst && !reset) begin
            dmemaddr   <= rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
            dmemdatain <= rs2_val;
            dmemop     <= funct3;
            dmemwe     <= (opcode == OP_STORE);
        end
    end

    // NOTE: the register file has no reset so it can map onto RAM; software initialises it.
    always_ff @(posedge clock) begin
        if (reg_we && rd != 5'd0)
            regs[rd] <= reg_wdata;
    end

`ifdef RV32I_MC_PERF_CNT_EN
    logic [31:0] cycle_q, instret_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            if (state != TRAP)
                cycle_q <= cycle_q + 32'd1;
            if (retire)
                instret_q <= instret_q + 32'd1;
        end
    end

    assign cyclecnt   = cycle_q;
    assign instretcnt = instret_q;
`else
    assign cyclecnt   = '0;
    assign instretcnt = '0;
`endif
endmodule

// File: tb/tb_rv32i_mc_core.sv
// Directed bench for rv32i_mc_core: zero-wait program, data wait states, branches/jumps,
// illegal-opcode trap, fetch/data watchdog traps and the ready-at-limit boundary.
module tb_rv32i_mc_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imemaddr, imemdataout, dmemaddr, dmemdatain, dmemdataout;
    logic [31:0] cyclecnt, instretcnt, dbgdata;
    logic [2:0]  dmemop;
    logic [1:0]  trapcause;
    logic        imemreq, imemready, dmemwe, dmemreq, dmemready, trap, retire;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef RV32I_MC_PERF_CNT_EN
    localparam logic [31:0] CYC_AT_13 = 32'd12, RET_AT_13 = 32'd3;
    localparam logic [31:0] CYC_AT_TRAP = 32'd27, RET_AT_TRAP = 32'd9;
`else
    localparam logic [31:0] CYC_AT_13 = 32'd0, RET_AT_13 = 32'd0;
    localparam logic [31:0] CYC_AT_TRAP = 32'd0, RET_AT_TRAP = 32'd0;
`endif

    rv32i_mc_core #(.RESET_PC(32'h100), .WAIT_LIMIT(4)) dut (
        .clock(clock), .reset(reset),
        .imemaddr(imemaddr), .imemreq(imemreq), .imemready(imemready), .imemdataout(imemdataout),
        .dmemaddr(dmemaddr), .dmemdatain(dmemdatain), .dmemdataout(dmemdataout),
        .dmemop(dmemop), .dmemwe(dmemwe), .dmemreq(dmemreq), .dmemready(dmemready),
        .trap(trap), .trapcause(trapcause), .retire(retire),
        .cyclecnt(cyclecnt), .instretcnt(instretcnt), .dbgdata(dbgdata)
    );

    always #5 clock = ~clock;

    // Memory responder: ready after a programmable number of wait cycles, or never when stalled.
    logic [31:0] imem [64];
    logic [31:0] dmem [16];
    int i_wait = 0, i_cnt = 0, d_cnt = 0;
    bit i_stall = 1'b0, d_stall = 1'b0;

    always @(posedge clock) begin
        i_cnt <= (imemreq && !imemready) ? i_cnt + 1 : 0;
        d_cnt <= (dmemreq && !dmemready) ? d_cnt + 1 : 0;
        if (dmemreq && dmemready && dmemwe)
            dmem[dmemaddr[5:2]] <= dmemdatain;
    end

    assign imemready   = imemreq && !i_stall && (i_cnt >= i_wait);
    assign imemdataout = imem[imemaddr[7:2]];
    assign dmemready   = dmemreq && !d_stall && (d_cnt >= ((dmemaddr == 32'd8) ? 3 : 0));
    assign dmemdataout = dmem[dmemaddr[5:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expected);
        n_checks++;
        if (got !== expected) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, expected);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check({tag, " imemreq in reset"}, imemreq, 0);
        check({tag, " dmemreq in reset"}, dmemreq, 0);
        repeat (2) next_cycle();
        check({tag, " trap in reset"}, trap, 0);
        check({tag, " retire in reset"}, retire, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        for (int i = 0; i < 64; i++) imem[i] = 32'h0;
        for (int i = 0; i < 16; i++) dmem[i] = 32'h0;
        imem[0]  = 32'h00500093; // 0x100 addi x1,x0,5
        imem[1]  = 32'h00108133; // 0x104 add  x2,x1,x1
        imem[2]  = 32'h00202023; // 0x108 sw   x2,0(x0)
        imem[3]  = 32'h00802183; // 0x10C lw   x3,8(x0)
        imem[4]  = 32'h00302623; // 0x110 sw   x3,12(x0)
        imem[5]  = 32'h00001463; // 0x114 bne  x0,x0,8
        imem[6]  = 32'h010002EF; // 0x118 jal  x5,16
        imem[8]  = 32'h00502823; // 0x120 sw   x5,16(x0)
        imem[9]  = 32'h00000000; // 0x124 illegal
        imem[10] = 32'hFE000CE3; // 0x128 beq  x0,x0,-8
        dmem[2]  = 32'hDEADBEEF;

        // Main program with zero-wait fetches and a 3-wait load
        do_reset("main");
        for (int cyc = 1; cyc <= 30; cyc++) begin
            check($sformatf("retire c%0d", cyc), retire,
                  (cyc inside {2, 4, 7, 13, 16, 18, 20, 22, 25}) ? 1 : 0);
            check($sformatf("dmemreq c%0d", cyc), dmemreq,
                  (cyc inside {7, 10, 11, 12, 13, 16, 25}) ? 1 : 0);
            case (cyc)
                1: begin
                    check("first imemreq", imemreq, 1);
                    check("first imemaddr", imemaddr, 32'h100);
                    check("first trap", trap, 0);
                    check("first dbgdata", dbgdata, 32'h100);
                    check("first cyclecnt", cyclecnt, 0);
                    check("first instretcnt", instretcnt, 0);
                end
                7: begin
                    check("sw1 addr", dmemaddr, 32'h0);
                    check("sw1 data", dmemdatain, 32'd10);
                    check("sw1 we", dmemwe, 1);
                    check("sw1 op", dmemop, 3'b010);
                end
                10, 11, 12, 13: begin
                    check($sformatf("lw addr c%0d", cyc), dmemaddr, 32'h8);
                    check($sformatf("lw we c%0d", cyc), dmemwe, 0);
                    check($sformatf("lw pc c%0d", cyc), dbgdata, 32'h10C);
                    if (cyc == 13) begin
                        check("cyclecnt c13", cyclecnt, CYC_AT_13);
                        check("instretcnt c13", instretcnt, RET_AT_13);
                    end
                end
                16: begin
                    check("sw x3 addr", dmemaddr, 32'hC);
                    check("sw x3 data", dmemdatain, 32'hDEADBEEF);
                    check("sw x3 we", dmemwe, 1);
                end
                19: check("bne not taken pc", imemaddr, 32'h118);
                21: check("jal target pc", imemaddr, 32'h128);
                23: check("beq -8 target pc", imemaddr, 32'h120);
                25: begin
                    check("jal link addr", dmemaddr, 32'h10);
                    check("jal link data", dmemdatain, 32'h11C);
                end
                27: check("illegal exec trap", trap, 0);
                28, 30: begin
                    check($sformatf("illegal trap c%0d", cyc), trap, 1);
                    check($sformatf("illegal cause c%0d", cyc), trapcause, 2'd1);
                    check($sformatf("illegal imemreq c%0d", cyc), imemreq, 0);
                    check($sformatf("illegal pc c%0d", cyc), dbgdata, 32'h124);
                    check($sformatf("trap cyclecnt c%0d", cyc), cyclecnt, CYC_AT_TRAP);
                    check($sformatf("trap instretcnt c%0d", cyc), instretcnt, RET_AT_TRAP);
                end
                default: ;
            endcase
            next_cycle();
        end
        check("stored word x2", dmem[0], 32'd10);

        // Fetch never acknowledged: watchdog fires after four wait cycles
        i_stall = 1'b1;
        do_reset("ftimeout");
        for (int cyc = 1; cyc <= 7; cyc++) begin
            if (cyc == 4) begin
                check("ftimeout trap c4", trap, 0);
                check("ftimeout imemreq c4", imemreq, 1);
            end
            if (cyc == 5 || cyc == 7) begin
                check($sformatf("ftimeout trap c%0d", cyc), trap, 1);
                check($sformatf("ftimeout cause c%0d", cyc), trapcause, 2'd2);
                check($sformatf("ftimeout imemreq c%0d", cyc), imemreq, 0);
                check($sformatf("ftimeout pc c%0d", cyc), dbgdata, 32'h100);
            end
            next_cycle();
        end

        // Ready arrives on the fourth wait cycle: completes normally
        i_stall = 1'b0;
        i_wait  = 3;
        do_reset("limit");
        for (int cyc = 1; cyc <= 6; cyc++) begin
            if (cyc == 1) check("recover pc", imemaddr, 32'h100);
            if (cyc == 4) check("limit retire c4", retire, 0);
            if (cyc == 5) begin
                check("limit retire c5", retire, 1);
                check("limit trap c5", trap, 0);
            end
            if (cyc == 6) check("limit next pc", imemaddr, 32'h104);
            next_cycle();
        end

        // Store never acknowledged: data watchdog fires
        i_wait  = 0;
        d_stall = 1'b1;
        do_reset("dtimeout");
        for (int cyc = 1; cyc <= 11; cyc++) begin
            if (cyc == 10) begin
                check("dtimeout trap c10", trap, 0);
                check("dtimeout dmemreq c10", dmemreq, 1);
            end
            if (cyc == 11) begin
                check("dtimeout trap c11", trap, 1);
                check("dtimeout cause c11", trapcause, 2'd3);
                check("dtimeout dmemreq c11", dmemreq, 0);
                check("dtimeout pc c11", dbgdata, 32'h108);
            end
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
